pbvi_decision_sched: RTL

Serial decision scheduler for the PBVI policy engine. It sequences a single shared multiply-accumulate over all stored alpha vectors for the current belief and tracks the running arg-max. It then publishes the chosen point action and raises the observation enable. It replaces the fully parallel 16-way product/compare tree with one multiplier pair fed from the alpha memory read port, and it owns that read port while a decision is in progress.

---
 rtl/pbvi_decision_sched.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pbvi_decision_sched.sv
// Serial PBVI decision scheduler: streams all alpha vectors through one multiplier pair,
// tracks the arg-max of belief . alpha and publishes the winning point action.
module pbvi_decision_sched #(
    parameter int unsigned N_ALPHA = 16,
    parameter int unsigned AW      = 4,
    parameter int unsigned DW      = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [DW-1:0]   belief0_i,
    input  logic [DW-1:0]   belief1_i,
    output logic            alpha_rd_o,
    output logic [AW-1:0]   alpha_addr_o,
    input  logic [DW-1:0]   alpha0_i,
    input  logic [DW-1:0]   alpha1_i,
    input  logic [1:0]      alpha_act_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            en_obs_o,
    output logic [1:0]      out_action_o,
    output logic [AW-1:0]   best_idx_o,
    output logic [2*DW:0]   best_value_o
);

    localparam int unsigned  VW       = 2 * DW + 1;
    localparam logic [AW-1:0] LastAddr = AW'(N_ALPHA - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   bel0_q, bel1_q;
    logic            valid_q;
    logic [AW-1:0]   idx_q;
    logic [VW-1:0]   best_val_q;
    logic [AW-1:0]   best_idx_q;
    logic [1:0]      best_act_q;
    logic [VW-1:0]   res_val_q;
    logic [AW-1:0]   res_idx_q;
    logic [1:0]      res_act_q;

    logic            publish;
    logic            accept;
    logic [2*DW-1:0] prod0, prod1;
    logic [VW-1:0]   value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StIssue;
            StIssue: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else if (addr_q == LastAddr) begin
                    state_d = StDrain;
                end
            end
            StDrain: state_d = abort_i ? StIdle : StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        alpha_rd_o   = (state_q == StIssue);
        alpha_addr_o = addr_q;
        busy_o       = (state_q != StIdle);
        publish      = (state_q == StDone) && !abort_i;
        done_o       = publish;
        en_obs_o     = publish;
        // Result becomes visible during the DONE cycle itself, then is held in res_*_q.
        out_action_o = publish ? best_act_q : res_act_q;
        best_idx_o   = publish ? best_idx_q : res_idx_q;
        best_value_o = publish ? best_val_q : res_val_q;
    end

    always_comb begin
        prod0  = {{DW{1'b0}}, bel0_q} * {{DW{1'b0}}, alpha0_i};
        prod1  = {{DW{1'b0}}, bel1_q} * {{DW{1'b0}}, alpha1_i};
        value  = {1'b0, prod0} + {1'b0, prod1};
        // Returned data is dropped once the run is cancelled.
        accept = valid_q && !abort_i && ((state_q == StIssue) || (state_q == StDrain));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            bel0_q     <= '0;
            bel1_q     <= '0;
            valid_q    <= 1'b0;
            idx_q      <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
            best_act_q <= '0;
            res_val_q  <= '0;
            res_idx_q  <= '0;
            res_act_q  <= '0;
        end else begin
            if (state_q == StIdle && start_i) begin
                addr_q <= '0;
                bel0_q <= belief0_i;
                bel1_q <= belief1_i;
            end else if (state_q == StIssue && addr_q != LastAddr) begin
                addr_q <= addr_q + 1'b1;
            end

            valid_q <= alpha_rd_o && !abort_i;
            idx_q   <= addr_q;

            if (accept && ((idx_q == '0) || (value > best_val_q))) begin
                best_val_q <= value;
                best_idx_q <= idx_q;
                best_act_q <= alpha_act_i;
            end

            if (publish) begin
                res_val_q <= best_val_q;
                res_idx_q <= best_idx_q;
                res_act_q <= best_act_q;
            end
        end
    end

endmodule
